// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer: serialises 32-bit IP words into Ethernet II GMII frames; optional stats via GMII_TX_STATS_EN
module gmii_tx_framer #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          IFG_BYTES   = 12,
  parameter int          MIN_PAYLOAD = 46,
  parameter int          MAX_PAYLOAD = 1500,
  parameter logic [15:0] ETHERTYPE   = 16'h0800
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] mac_data,
  input  logic [15:0]           mac_len,
  input  logic                  mac_valid,
  output logic                  mac_ready,
  input  logic [47:0]           dst_mac,
  input  logic [47:0]           src_mac,
  output logic [7:0]            gmii_txd,
  output logic                  gmii_tx_en,
  output logic                  gmii_tx_er,
  output logic                  frame_done,
  output logic                  len_err,
  output logic                  underrun
`ifdef GMII_TX_STATS_EN
  ,
  output logic [31:0]           tx_frame_count,
  output logic [31:0]           tx_byte_count
`endif
);
  typedef enum logic [3:0] {IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, PAD, FCS, IFG, DRAIN} state_t;
  state_t state_q, state_d;
  logic [15:0] len_q, len_d, pay_q, pay_d, wc_q, wc_d, wc_nx, nw;
  logic [47:0] dst_q, dst_d, src_q, src_d;
  logic [7:0] cnt_q, cnt_d;
  logic [31:0] sr_q, sr_d, crc_q, crc_d, fsh;
  logic [1:0] sr_n_q, sr_n_d;
  logic [16:0] len3;
  logic [111:0] hsh;
  logic open, start, bad, need, take, acc, last_pay;

  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction

  // the last IFG cycle may already accept the next packet so the gap is exactly IFG_BYTES
  assign open     = state_q == IDLE || (state_q == IFG && cnt_q == 8'(IFG_BYTES - 1));
  assign bad      = mac_len == 16'd0 || mac_len > 16'(MAX_PAYLOAD);
  assign start    = open && mac_valid;
  assign need     = state_q == PAYLOAD && sr_n_q == 2'd0;
  assign take     = need && mac_valid;
  assign acc      = mac_valid && mac_ready;
  assign wc_nx    = wc_q + {15'd0, acc};
  assign len3     = {1'b0, len_q} + 17'd3;
  assign nw       = {1'b0, len3[16:2]};
  assign last_pay = pay_q == len_q - 16'd1;
  assign hsh      = {dst_q, src_q, ETHERTYPE} << {cnt_q[3:0], 3'b000};
  assign fsh      = ~crc_q >> {cnt_q[1:0], 3'b000};

  // state register
  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, IFG: if (open) state_d = !mac_valid ? IDLE : bad ? DRAIN : PREAMBLE;
      PREAMBLE:  if (cnt_q == 8'd6) state_d = SFD;
      SFD:       state_d = HEADER;
      HEADER:    if (cnt_q == 8'd13) state_d = PAYLOAD;
      PAYLOAD:   state_d = (need && !mac_valid) ? DRAIN : !last_pay ? PAYLOAD : len_q < 16'(MIN_PAYLOAD) ? PAD : FCS;
      PAD:       if (pay_q == 16'(MIN_PAYLOAD - 1)) state_d = FCS;
      FCS:       if (cnt_q == 8'd3) state_d = IFG;
      DRAIN:     if (wc_nx == nw) state_d = IFG;
      default:   state_d = IDLE;
    endcase
  end

  // outputs; the first byte of a new word bypasses the shift register
  always_comb begin
    mac_ready  = need || (state_q == DRAIN && wc_q != nw);
    gmii_tx_en = state_q inside {PREAMBLE, SFD, HEADER, PAYLOAD, PAD, FCS};
    gmii_txd   = state_q == PREAMBLE ? 8'h55 :
                 state_q == SFD      ? 8'hD5 :
                 state_q == HEADER   ? hsh[111:104] :
                 state_q == PAYLOAD  ? (need ? (mac_valid ? mac_data[DATA_WIDTH-1 -: 8] : 8'h00) : sr_q[31:24]) :
                 state_q == FCS      ? fsh[7:0] : 8'h00;
    gmii_tx_er = need && !mac_valid;
    underrun   = need && !mac_valid;
    frame_done = state_q == FCS && cnt_q == 8'd3;
    len_err    = start && bad;
  end

  // datapath next values
  always_comb begin
    cnt_d  = state_d != state_q ? 8'd0 : cnt_q + 8'd1;
    pay_d  = (state_q == PAYLOAD || state_q == PAD) ? pay_q + 16'd1 : 16'd0;
    wc_d   = start ? 16'd0 : wc_nx;
    sr_d   = take ? {mac_data[DATA_WIDTH-9:0], 8'h00} : sr_q << 8;
    sr_n_d = start ? 2'd0 : take ? 2'd3 : sr_n_q - {1'b0, sr_n_q != 2'd0};
    len_d  = start ? mac_len : len_q;
    dst_d  = start ? dst_mac : dst_q;
    src_d  = start ? src_mac : src_q;
    crc_d  = start ? 32'hFFFFFFFF : (state_q inside {HEADER, PAYLOAD, PAD}) ? crc8(crc_q, gmii_txd) : crc_q;
  end

  // datapath registers
  always_ff @(posedge clk)
    if (rst) begin
      cnt_q  <= '0;
      pay_q  <= '0;
      wc_q   <= '0;
      sr_q   <= '0;
      sr_n_q <= '0;
      len_q  <= '0;
      dst_q  <= '0;
      src_q  <= '0;
      crc_q  <= 32'hFFFFFFFF;
    end else begin
      cnt_q  <= cnt_d;
      pay_q  <= pay_d;
      wc_q   <= wc_d;
      sr_q   <= sr_d;
      sr_n_q <= sr_n_d;
      len_q  <= len_d;
      dst_q  <= dst_d;
      src_q  <= src_d;
      crc_q  <= crc_d;
    end

`ifdef GMII_TX_STATS_EN
  logic [31:0] tx_frame_count_q, tx_frame_count_d, tx_byte_count_q, tx_byte_count_d;

  // completed frames and their header+payload+pad+FCS bytes
  always_comb begin
    tx_frame_count_d = tx_frame_count_q + {31'd0, frame_done};
    tx_byte_count_d  = tx_byte_count_q + (frame_done ? 32'd18 + {16'd0, len_q < 16'(MIN_PAYLOAD) ? 16'(MIN_PAYLOAD) : len_q} : 32'd0);
  end

  // statistics registers
  always_ff @(posedge clk)
    if (rst) begin
      tx_frame_count_q <= '0;
      tx_byte_count_q  <= '0;
    end else begin
      tx_frame_count_q <= tx_frame_count_d;
      tx_byte_count_q  <= tx_byte_count_d;
    end

  assign tx_frame_count = tx_frame_count_q;
  assign tx_byte_count  = tx_byte_count_q;
`endif
endmodule

// File: doc/gmii_tx_framer.md
Name: gmii_tx_framer

Overview:
- Downstream neighbour of the UDP/IP stack. Consumes the stack's 32-bit IP-packet word stream (mac_data/mac_len/mac_valid) and emits a complete Ethernet II frame as GMII bytes at 125 MHz.
- Frame on the wire: preamble, SFD, 14-byte Ethernet header, payload, zero pad up to the minimum payload size, CRC-32 FCS, then inter-frame gap.
- Adds a ready back-pressure so the stack can hold words while the framer serialises.

Parameters:
- DATA_WIDTH, 32, input word width; only 32 is supported.
- IFG_BYTES, 12, idle cycles after the last FCS byte; minimum 12.
- MIN_PAYLOAD, 46, payload bytes below which zero padding is added.
- MAX_PAYLOAD, 1500, largest accepted mac_len.
- ETHERTYPE, 16'h0800, EtherType inserted in the header.

Ports:
- clk  in  1  125 MHz GMII TX clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- mac_data  in  32  payload word, MSB byte first on the wire.
- mac_len  in  16  payload byte count; valid with the first word of a packet.
- mac_valid  in  1  word valid.
- mac_ready  out  1  word accepted when mac_valid && mac_ready.
- dst_mac  in  48  destination MAC; sampled at frame start.
- src_mac  in  48  source MAC; sampled at frame start.
- gmii_txd  out  8  GMII TX data.
- gmii_tx_en  out  1  GMII TX enable.
- gmii_tx_er  out  1  GMII TX error.
- frame_done  out  1  one-cycle pulse on the last FCS byte.
- len_err  out  1  one-cycle pulse when mac_len is 0 or greater than MAX_PAYLOAD.
- underrun  out  1  one-cycle pulse when a word is needed but mac_valid is low.

Behaviour:
- Reset values: all outputs 0; state IDLE; CRC register 0xFFFFFFFF.
- Reset asserted mid-frame: gmii_tx_en is 0 on the next edge, the partial frame is abandoned, and nothing resumes afterwards.
- States: IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, PAD, FCS, IFG, DRAIN.
- IDLE:
  - mac_ready=0.
  - When mac_valid=1, latch mac_len, dst_mac and src_mac. No word is consumed here.
  - If len is 0 or > MAX_PAYLOAD: pulse len_err and go to DRAIN.
  - Otherwise go to PREAMBLE; the first byte appears on gmii_txd one cycle after the latch.
- PREAMBLE: 7 cycles of 0x55 with tx_en=1.
- SFD: 1 cycle of 0xD5.
- HEADER: 14 cycles in this byte order: dst_mac[47:40] first through dst_mac[7:0], then src_mac in the same order, then ETHERTYPE high byte, then low byte.
- PAYLOAD:
  - A 32-bit shift register serialises [31:24], [23:16], [15:8], [7:0].
  - mac_ready=1 only in the cycle a new word is needed, i.e. the register is empty and bytes remain.
  - The word is accepted in that same cycle and its first byte is driven in that cycle (combinational bypass). Sustained throughput is 1 word per 4 cycles.
  - The final word has ceil(len/4) position; its unused low bytes are discarded.
  - After len bytes: go to PAD if len < MIN_PAYLOAD, else FCS.
- PAD: 0x00 bytes until MIN_PAYLOAD payload bytes have been sent in total.
- FCS:
  - CRC is IEEE 802.3 CRC-32 (reflected polynomial 0xEDB88320, init 0xFFFFFFFF) over header, payload and pad.
  - The final value is complemented and sent over 4 cycles, LSB byte first.
  - frame_done pulses with the 4th FCS byte.
- IFG: IFG_BYTES cycles with tx_en=0 and txd=0, then IDLE. The next preamble cannot start earlier.
- Underrun (mac_valid=0 when mac_ready=1 in PAYLOAD):
  - That cycle drives txd=0x00, tx_en=1, tx_er=1 and pulses underrun.
  - Then go to DRAIN. The CRC for the aborted frame is not sent.
- DRAIN:
  - tx_en=0, mac_ready=1.
  - Discard words until ceil(len/4) words of the packet have been consumed in total, counting any already accepted.
  - Then go to IFG.
- Wire length per frame = 8 + 14 + max(len, MIN_PAYLOAD) + 4 bytes, with tx_en high contiguously for the whole frame.
- gmii_tx_er is 0 in every case except the underrun cycle.

Optional Feature:
- Macro: GMII_TX_STATS_EN.
- When defined, two extra outputs exist:
  - tx_frame_count [31:0]: +1 on every frame_done.
  - tx_byte_count [31:0]: +(wire length excluding preamble/SFD) on frame_done.
- Both counters wrap modulo 2^32 and are cleared by rst. Aborted frames are counted in neither.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- mac_len=28, one packet (7 words, e.g. IP header starting 0x45000024…), dst_mac=FF:FF:FF:FF:FF:FF, src_mac=02:00:00:00:00:01 -> tx_en high exactly 72 cycles; bytes are 7×0x55, 0xD5, header FF×6, 02 00 00 00 00 01, 08 00, then 28 payload bytes, 18×0x00, then FCS. Running the CRC over header..FCS yields residue 0xC704DD7B; frame_done at cycle 72.
- mac_len=1500 with continuous mac_valid -> 1526 tx_en cycles, no pad, mac_ready asserted exactly 375 times, FCS matches the bench reference model.
- Back-to-back packets with mac_valid held high -> exactly 12 tx_en=0 cycles between the last FCS byte and the next 0x55.
- mac_len=1501, then mac_len=0 -> len_err pulses for each; 376 words (1501 case) and 0 words (0 case) drained; gmii_tx_en stays 0 throughout.
- mac_len=16, mac_valid dropped when the 3rd word is requested -> that cycle has tx_er=1, tx_en=1, txd=0x00, underrun pulses; remaining 2 words are consumed in DRAIN; 12 idle cycles follow; the next frame is correct.
- rst pulsed at payload byte 10 -> tx_en=0 on the next edge; the following packet produces a clean frame. With GMII_TX_STATS_EN: tx_frame_count=1 and tx_byte_count=64 after the 28-byte frame.
